// File: rtl/rvsteel_reset_sequencer_pkg.sv
// Shared types and helpers for the board reset/halt sequencer.
package rvsteel_reset_sequencer_pkg;

  // Sequencer states: holding the SoC in reset for a fixed window, letting it
  // run, or waiting for the reset button to be released.
  typedef enum logic [1:0] {
    SEQ_HOLD    = 2'd0,
    SEQ_RUN     = 2'd1,
    SEQ_PRESSED = 2'd2
  } seq_state_e;

  // Counter width that can hold the value n without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rvsteel_reset_sequencer_debouncer.sv
// Two-flop synchroniser followed by a stability-count debouncer for one
// raw pushbutton. The debounced level only follows the synchronised level
// once it has differed for DEBOUNCE_CYCLES consecutive cycles.
module rvsteel_debouncer
  import rvsteel_reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  output logic button_debounced
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_level;

  assign sync_level = sync_q[1];

  // Shift the raw pin into the synchroniser and count how long the
  // synchronised level has disagreed with the debounced level.
  always_comb begin
    sync_d = {sync_q[0], button_raw};
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_level != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards all debounce history.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign button_debounced = deb_q;

endmodule

// File: rtl/rvsteel_reset_sequencer.sv
// Board-level sequencer between the pushbuttons and rvsteel_soc: debounces
// the reset and halt buttons, stretches SoC reset over a hold window and
// toggles SoC halt on each debounced halt press while the SoC runs.
module rvsteel_reset_sequencer
  import rvsteel_reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic reset_button,
  input  logic halt_button,
  output logic soc_reset,
  output logic soc_halt,
  output logic soc_running
);

  localparam int unsigned HOLD_W = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  logic deb_reset;
  logic deb_halt;
  logic halt_press;

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              halt_prev_q, halt_prev_d;
  logic              soc_reset_q, soc_reset_d;
  logic              soc_halt_q, soc_halt_d;
  logic              soc_running_q, soc_running_d;

  rvsteel_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_reset_debouncer (
    .clock           (clock),
    .reset           (reset),
    .button_raw      (reset_button),
    .button_debounced(deb_reset)
  );

  rvsteel_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_halt_debouncer (
    .clock           (clock),
    .reset           (reset),
    .button_raw      (halt_button),
    .button_debounced(deb_halt)
  );

  assign halt_press = deb_halt & ~halt_prev_q;

  // Next-state and next-output logic; outputs are derived from the next
  // state so they change in the same cycle as the state register.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    halt_prev_d = deb_halt;
    soc_halt_d  = soc_halt_q;
    case (state_q)
      SEQ_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = deb_reset ? SEQ_PRESSED : SEQ_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      SEQ_RUN: begin
        if (deb_reset) begin
          state_d = SEQ_PRESSED;
        end else if (halt_press) begin
          soc_halt_d = ~soc_halt_q;
        end
      end
      SEQ_PRESSED: begin
        if (!deb_reset) begin
          state_d    = SEQ_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = SEQ_HOLD;
        hold_cnt_d = '0;
      end
    endcase
    soc_reset_d   = (state_d != SEQ_RUN);
    soc_running_d = (state_d == SEQ_RUN);
    if (state_d != SEQ_RUN) begin
      soc_halt_d = 1'b0;
    end
  end

  // Single register bank for the FSM, its counter and the registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SEQ_HOLD;
      hold_cnt_q    <= '0;
      halt_prev_q   <= 1'b0;
      soc_reset_q   <= 1'b1;
      soc_halt_q    <= 1'b0;
      soc_running_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      halt_prev_q   <= halt_prev_d;
      soc_reset_q   <= soc_reset_d;
      soc_halt_q    <= soc_halt_d;
      soc_running_q <= soc_running_d;
    end
  end

  assign soc_reset   = soc_reset_q;
  assign soc_halt    = soc_halt_q;
  assign soc_running = soc_running_q;

endmodule

// File: tb/tb_rvsteel_reset_sequencer.sv
// Bench for rvsteel_reset_sequencer: instance A uses DEBOUNCE_CYCLES=4,
// RESET_HOLD_CYCLES=8; instance B uses 1/1 for boundary behaviour.
// Directed scenarios use hand-derived timing; a randomized run compares both
// instances every cycle against a behavioural model.
module tb_rvsteel_reset_sequencer;

  logic clock;
  logic reset;
  logic rbtn_a, hbtn_a, rbtn_b, hbtn_b;
  logic soc_reset_a, soc_halt_a, soc_running_a;
  logic soc_reset_b, soc_halt_b, soc_running_b;
  logic [2:0] obs_a, obs_b;

  int pass_count;
  int check_count;

  assign obs_a = {soc_reset_a, soc_halt_a, soc_running_a};
  assign obs_b = {soc_reset_b, soc_halt_b, soc_running_b};

  rvsteel_reset_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD_CYCLES(8)
  ) dut_a (
    .clock       (clock),
    .reset       (reset),
    .reset_button(rbtn_a),
    .halt_button (hbtn_a),
    .soc_reset   (soc_reset_a),
    .soc_halt    (soc_halt_a),
    .soc_running (soc_running_a)
  );

  rvsteel_reset_sequencer #(
    .DEBOUNCE_CYCLES(1),
    .RESET_HOLD_CYCLES(1)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .reset_button(rbtn_b),
    .halt_button (hbtn_b),
    .soc_reset   (soc_reset_b),
    .soc_halt    (soc_halt_b),
    .soc_running (soc_running_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: pin history per button, debounced level flips when
  // the last DEBOUNCE_CYCLES synchronised samples all disagree with it.
  int  dcyc[2];
  int  hcyc[2];
  bit  hist[2][2][8];
  bit  m_deb[2][2];
  bit  m_prev[2];
  bit  m_run[2];
  bit  m_pr[2];
  bit  m_halt[2];
  int  m_held[2];

  task automatic model_step(input int i, input bit rst, input bit pin_r, input bit pin_h);
    bit dr, dh, press, diff;
    bit pins[2];
    pins[0] = pin_r;
    pins[1] = pin_h;
    if (rst) begin
      m_run[i] = 0; m_pr[i] = 0; m_held[i] = 0; m_halt[i] = 0; m_prev[i] = 0;
      for (int b = 0; b < 2; b++) begin
        m_deb[i][b] = 0;
        for (int j = 0; j < 8; j++) hist[i][b][j] = 0;
      end
    end else begin
      dr = m_deb[i][0];
      dh = m_deb[i][1];
      press = dh && !m_prev[i];
      m_prev[i] = dh;
      if (m_run[i]) begin
        if (dr) begin
          m_run[i] = 0; m_pr[i] = 1; m_halt[i] = 0;
        end else if (press) begin
          m_halt[i] = !m_halt[i];
        end
      end else if (m_pr[i]) begin
        if (!dr) begin
          m_pr[i] = 0; m_held[i] = 0;
        end
      end else begin
        m_held[i]++;
        if (m_held[i] == hcyc[i]) begin
          m_held[i] = 0;
          if (dr) m_pr[i] = 1;
          else m_run[i] = 1;
        end
      end
      for (int b = 0; b < 2; b++) begin
        diff = 1;
        for (int k = 1; k <= dcyc[i]; k++) if (hist[i][b][k] == m_deb[i][b]) diff = 0;
        if (diff) m_deb[i][b] = !m_deb[i][b];
        for (int j = 7; j > 0; j--) hist[i][b][j] = hist[i][b][j-1];
        hist[i][b][0] = pins[b];
      end
    end
  endtask

  // One clock: advance the model with the inputs seen at the rising edge,
  // then return at the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clock);
    model_step(0, reset, rbtn_a, hbtn_a);
    model_step(1, reset, rbtn_b, hbtn_b);
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    reset = 1; rbtn_a = 0; hbtn_a = 0; rbtn_b = 0; hbtn_b = 0;
    repeat (3) step();
    check_count++;
    if (obs_a !== 3'b100) $display("[TB] FAIL reset_state_a got %b want %b", obs_a, 3'b100);
    else pass_count++;
    check_count++;
    if (obs_b !== 3'b100) $display("[TB] FAIL reset_state_b got %b want %b", obs_b, 3'b100);
    else pass_count++;
    reset = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = (k >= 8) ? 3'b001 : 3'b100;
      check_count++;
      if (obs_a !== exp) $display("[TB] FAIL hold_window_a k=%0d got %b want %b", k, obs_a, exp);
      else pass_count++;
      check_count++;
      if (obs_b !== 3'b001) $display("[TB] FAIL hold_window_b k=%0d got %b want %b", k, obs_b, 3'b001);
      else pass_count++;
    end
  endtask

  task automatic test_glitch_and_press();
    logic [2:0] exp;
    rbtn_a = 1;
    repeat (3) step();
    rbtn_a = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_count++;
      if (obs_a !== 3'b001) $display("[TB] FAIL glitch_reject k=%0d got %b want %b", k, obs_a, 3'b001);
      else pass_count++;
    end
    rbtn_a = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = (k >= 7) ? 3'b100 : 3'b001;
      check_count++;
      if (obs_a !== exp) $display("[TB] FAIL reset_press k=%0d got %b want %b", k, obs_a, exp);
      else pass_count++;
    end
    rbtn_a = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      exp = (k >= 15) ? 3'b001 : 3'b100;
      check_count++;
      if (obs_a !== exp) $display("[TB] FAIL reset_release k=%0d got %b want %b", k, obs_a, exp);
      else pass_count++;
    end
  endtask

  task automatic test_halt_toggle();
    logic old_h;
    logic [2:0] exp;
    for (int p = 0; p < 2; p++) begin
      old_h = (p == 1);
      hbtn_a = 1;
      for (int k = 1; k <= 10; k++) begin
        step();
        exp = {1'b0, (k >= 7) ? ~old_h : old_h, 1'b1};
        check_count++;
        if (obs_a !== exp) $display("[TB] FAIL halt_press%0d k=%0d got %b want %b", p, k, obs_a, exp);
        else pass_count++;
      end
      hbtn_a = 0;
      for (int k = 1; k <= 10; k++) begin
        step();
        exp = {1'b0, ~old_h, 1'b1};
        check_count++;
        if (obs_a !== exp) $display("[TB] FAIL halt_release%0d k=%0d got %b want %b", p, k, obs_a, exp);
        else pass_count++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    hbtn_a = 1;
    repeat (10) step();
    hbtn_a = 0;
    repeat (10) step();
    check_count++;
    if (obs_a !== 3'b011) $display("[TB] FAIL simul_setup got %b want %b", obs_a, 3'b011);
    else pass_count++;
    rbtn_a = 1; hbtn_a = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k >= 7) ? 3'b100 : 3'b011;
      check_count++;
      if (obs_a !== exp) $display("[TB] FAIL simul_press k=%0d got %b want %b", k, obs_a, exp);
      else pass_count++;
    end
    rbtn_a = 0; hbtn_a = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = (k >= 15) ? 3'b001 : 3'b100;
      check_count++;
      if (obs_a !== exp) $display("[TB] FAIL simul_release k=%0d got %b want %b", k, obs_a, exp);
      else pass_count++;
    end
  endtask

  task automatic test_held_through_reset();
    logic [2:0] exp;
    rbtn_a = 1; reset = 1;
    repeat (3) step();
    reset = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      check_count++;
      if (obs_a !== 3'b100) $display("[TB] FAIL held_button k=%0d got %b want %b", k, obs_a, 3'b100);
      else pass_count++;
    end
    rbtn_a = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = (k >= 15) ? 3'b001 : 3'b100;
      check_count++;
      if (obs_a !== exp) $display("[TB] FAIL held_release k=%0d got %b want %b", k, obs_a, exp);
      else pass_count++;
    end
  endtask

  task automatic test_reset_mid_state();
    logic [2:0] exp;
    rbtn_a = 1; rbtn_b = 1;
    repeat (10) step();
    check_count++;
    if ({obs_a, obs_b} !== 6'b100100) $display("[TB] FAIL mid_pressed_setup got %b want %b", {obs_a, obs_b}, 6'b100100);
    else pass_count++;
    reset = 1; rbtn_a = 0; rbtn_b = 0;
    step();
    check_count++;
    if ({obs_a, obs_b} !== 6'b100100) $display("[TB] FAIL reset_in_pressed got %b want %b", {obs_a, obs_b}, 6'b100100);
    else pass_count++;
    reset = 0;
    repeat (5) step();
    reset = 1;
    step();
    check_count++;
    if (obs_a !== 3'b100) $display("[TB] FAIL reset_in_hold got %b want %b", obs_a, 3'b100);
    else pass_count++;
    reset = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (k >= 8) ? 3'b001 : 3'b100;
      check_count++;
      if (obs_a !== exp) $display("[TB] FAIL hold_restart k=%0d got %b want %b", k, obs_a, exp);
      else pass_count++;
      check_count++;
      if (obs_b !== 3'b001) $display("[TB] FAIL hold_restart_b k=%0d got %b want %b", k, obs_b, 3'b001);
      else pass_count++;
    end
  endtask

  task automatic test_boundary_halt();
    logic [2:0] exp;
    hbtn_b = 1;
    step();
    hbtn_b = 0;
    for (int k = 2; k <= 8; k++) begin
      step();
      exp = {1'b0, (k >= 4), 1'b1};
      check_count++;
      if (obs_b !== exp) $display("[TB] FAIL boundary_halt k=%0d got %b want %b", k, obs_b, exp);
      else pass_count++;
    end
  endtask

  task automatic test_random();
    int len[2][2];
    bit val[2][2];
    int rst_left;
    logic [2:0] exp_a, exp_b;
    rst_left = 0;
    for (int i = 0; i < 2; i++) for (int b = 0; b < 2; b++) begin
      len[i][b] = 0; val[i][b] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < 2; b++) begin
          if (len[i][b] == 0) begin
            val[i][b] = (b == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            len[i][b] = (i == 0) ? $urandom_range(1, 12) : $urandom_range(1, 4);
          end
          len[i][b]--;
        end
      end
      rbtn_a = val[0][0]; hbtn_a = val[0][1];
      rbtn_b = val[1][0]; hbtn_b = val[1][1];
      if (rst_left > 0) begin
        reset = 1; rst_left--;
      end else begin
        reset = 0;
        if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      end
      step();
      exp_a = {!m_run[0], m_halt[0], m_run[0]};
      exp_b = {!m_run[1], m_halt[1], m_run[1]};
      check_count++;
      if (obs_a !== exp_a) $display("[TB] FAIL random_a cyc=%0d got %b want %b", cyc, obs_a, exp_a);
      else pass_count++;
      check_count++;
      if (obs_b !== exp_b) $display("[TB] FAIL random_b cyc=%0d got %b want %b", cyc, obs_b, exp_b);
      else pass_count++;
    end
  endtask

  initial begin
    pass_count = 0;
    check_count = 0;
    dcyc[0] = 4; hcyc[0] = 8;
    dcyc[1] = 1; hcyc[1] = 1;
    reset = 1; rbtn_a = 0; hbtn_a = 0; rbtn_b = 0; hbtn_b = 0;
    $display("[TB] starting");
    test_reset();
    test_glitch_and_press();
    test_halt_toggle();
    test_simultaneous();
    test_held_through_reset();
    test_reset_mid_state();
    test_boundary_halt();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
